// File: rtl/addsub_serial.sv
// Multi-cycle adder/subtractor that handles SLICE bits of a WIDTH-bit
// operation per clock, with a start/busy/done handshake.
module addsub_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH
        || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("addsub_serial: illegal WIDTH/SLICE");
    end
  endgenerate

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic             carry;

  logic [SLICE-1:0]       sa;
  logic [SLICE-1:0]       sb;
  logic [SLICE:0]         ssum;
  logic                   cin_msb;
  logic [WIDTH+SLICE-1:0] cat;
  logic [WIDTH-1:0]       acc_nxt;
  logic                   last;

  // b is pre-inverted at start, so subtract is a + ~b + 1
  always_comb begin
    sa      = a_q[SLICE-1:0];
    sb      = b_q[SLICE-1:0];
    ssum    = {1'b0, sa} + {1'b0, sb}
            + {{SLICE{1'b0}}, carry};
    cin_msb = sa[SLICE-1] ^ sb[SLICE-1]
            ^ ssum[SLICE-1];
    cat     = {ssum[SLICE-1:0], acc};
    acc_nxt = WIDTH'(cat >> SLICE);
    last    = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        (state == RUN): begin
          a_q   <= a_q >> SLICE;
          b_q   <= b_q >> SLICE;
          carry <= ssum[SLICE];
          acc   <= acc_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            result <= acc_nxt;
            cout   <= ssum[SLICE];
            ovf    <= cin_msb ^ ssum[SLICE];
            zero   <= (acc_nxt == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed 8/2 scenarios plus a randomized
// sweep over several WIDTH/SLICE pairs against an arithmetic model.
module tb_addsub_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;
  logic       zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  logic        sw_start [4];
  logic        sw_sub   [4];
  logic [31:0] sw_a     [4];
  logic [31:0] sw_b     [4];
  logic        sw_busy  [4];
  logic        sw_done  [4];
  logic [31:0] sw_res   [4];
  logic        sw_cout  [4];
  logic        sw_ovf   [4];
  logic        sw_zero  [4];

  for (genvar k = 0; k < 4; k++) begin : g_sw
    localparam int W = (k < 2) ? 8 : (k == 2) ? 16 : 32;
    localparam int S = (k == 0) ? 1 : (k == 2) ? 4 : 8;
    logic [W-1:0] r;
    addsub_serial #(.WIDTH(W), .SLICE(S)) u (
      .clk(clk), .rst_n(rst_n),
      .start(sw_start[k]), .sub(sw_sub[k]),
      .a(sw_a[k][W-1:0]), .b(sw_b[k][W-1:0]),
      .busy(sw_busy[k]), .done(sw_done[k]),
      .result(r), .cout(sw_cout[k]),
      .ovf(sw_ovf[k]), .zero(sw_zero[k])
    );
    assign sw_res[k] = 32'(r);
  end

  // Reference: {cout, ovf, zero, result} from plain integer arithmetic
  function automatic logic [34:0] ref_op(input int w, input logic s,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    longint m, half, ux, uy, full, res, sx, sy, sf;
    logic c, o, z;
    m    = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    ux   = longint'(x) & m;
    uy   = longint'(y) & m;
    full = s ? ux - uy : ux + uy;
    res  = full & m;
    c    = s ? (ux >= uy) : (full > m);
    sx   = (ux >= half) ? ux - (m + 1) : ux;
    sy   = (uy >= half) ? uy - (m + 1) : uy;
    sf   = s ? sx - sy : sx + sy;
    o    = (sf < -half) || (sf >= half);
    z    = (res == 0);
    return {c, o, z, res[31:0]};
  endfunction

  // Start one op on the 8/2 instance; returns edges from start to done
  task automatic run_main(input logic s, input logic [7:0] x,
                          input logic [7:0] y, output int lat);
    @(negedge clk);
    start = 1'b1; sub = s; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    sub = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat;
    logic [34:0] exp;
    #1;
    n_cmp++;
    if ({busy, done, result, cout, ovf, zero} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_hold got=%h want=000",
               {busy, done, result, cout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_main(1'b0, 8'h35, 8'h4A, lat);
    exp = ref_op(8, 1'b0, 32'h35, 32'h4A);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL first_latency got=%0d want=4", lat);
    end
    n_cmp++;
    if ({cout, ovf, zero, 24'h0, result} !== exp) begin
      n_bad++;
      $display("FAIL first_add got=%h want=%h",
               {cout, ovf, zero, 24'h0, result}, exp);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, result, cout, ovf, zero} !== 12'h000) begin
      n_bad++;
      $display("FAIL async_reset got=%h want=000",
               {busy, done, result, cout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors(input string tag,
                              input logic [16:0] vec [3]);
    int lat;
    logic [34:0] exp;
    for (int i = 0; i < 3; i++) begin
      run_main(vec[i][16], vec[i][15:8], vec[i][7:0], lat);
      exp = ref_op(8, vec[i][16], 32'(vec[i][15:8]),
                   32'(vec[i][7:0]));
      n_cmp++;
      if (lat !== 4) begin
        n_bad++;
        $display("FAIL %s_latency[%0d] got=%0d want=4", tag, i, lat);
      end
      n_cmp++;
      if ({cout, ovf, zero, 24'h0, result} !== exp) begin
        n_bad++;
        $display("FAIL %s[%0d] got=%h want=%h", tag, i,
                 {cout, ovf, zero, 24'h0, result}, exp);
      end
    end
  endtask

  task automatic test_subtract;
    logic [16:0] v [3];
    v[0] = {1'b1, 8'h50, 8'h30};
    v[1] = {1'b1, 8'h30, 8'h50};
    v[2] = {1'b1, 8'h42, 8'h42};
    test_vectors("sub", v);
  endtask

  task automatic test_overflow;
    logic [16:0] v [3];
    v[0] = {1'b0, 8'h7F, 8'h01};
    v[1] = {1'b1, 8'h80, 8'h01};
    v[2] = {1'b0, 8'hFF, 8'h01};
    test_vectors("ovf", v);
  endtask

  task automatic test_ignore_busy;
    int lat;
    logic [34:0] exp;
    exp = ref_op(8, 1'b0, 32'h11, 32'h22);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 8'hF0; b = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL busy_latency got=%0d want=4", lat);
    end
    n_cmp++;
    if ({cout, ovf, zero, 24'h0, result} !== exp) begin
      n_bad++;
      $display("FAIL busy_ignore got=%h want=%h",
               {cout, ovf, zero, 24'h0, result}, exp);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [34:0] exp;
    run_main(1'b0, 8'h12, 8'h34, lat);
    start = 1'b1; sub = 1'b1; a = 8'hA5; b = 8'h3C;
    exp = ref_op(8, 1'b1, 32'hA5, 32'h3C);
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept done=%b busy=%b want done=0 busy=1",
               done, busy);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL b2b_latency got=%0d want=4", lat);
    end
    n_cmp++;
    if ({cout, ovf, zero, 24'h0, result} !== exp) begin
      n_bad++;
      $display("FAIL b2b_result got=%h want=%h",
               {cout, ovf, zero, 24'h0, result}, exp);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || result !== exp[7:0]) begin
      n_bad++;
      $display("FAIL done_width done=%b result=%h want done=0 result=%h",
               done, result, exp[7:0]);
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    int seen;
    logic [34:0] exp;
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 8'h21; b = 8'h13;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
      n_bad++;
      $display("FAIL mid_reset busy=%b done=%b result=%h want 0/0/00",
               busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_no_done got=%0d pulses want=0", seen);
    end
    run_main(1'b1, 8'h9C, 8'h27, lat);
    exp = ref_op(8, 1'b1, 32'h9C, 32'h27);
    n_cmp++;
    if (lat !== 4 || {cout, ovf, zero, 24'h0, result} !== exp) begin
      n_bad++;
      $display("FAIL post_reset_op lat=%0d got=%h want lat=4 %h", lat,
               {cout, ovf, zero, 24'h0, result}, exp);
    end
  endtask

  task automatic test_sweep(input int k, input int w, input int s);
    int lat;
    int bad_lat;
    int bad_val;
    logic        op;
    logic [31:0] x, y;
    logic [34:0] exp;
    bad_lat = 0;
    bad_val = 0;
    for (int i = 0; i < 1000; i++) begin
      op = 1'($urandom);
      x  = $urandom;
      y  = $urandom;
      if ((i % 50) == 0) y = x;
      exp = ref_op(w, op, x, y);
      @(negedge clk);
      sw_start[k] = 1'b1; sw_sub[k] = op; sw_a[k] = x; sw_b[k] = y;
      @(posedge clk);
      #1;
      sw_start[k] = 1'b0;
      sw_a[k] = $urandom; sw_b[k] = $urandom;
      lat = 0;
      for (int j = 1; j <= 40; j++) begin
        @(posedge clk);
        #1;
        if (sw_done[k]) begin
          lat = j;
          break;
        end
      end
      n_cmp++;
      if (lat !== w / s) begin
        n_bad++;
        if (bad_lat++ < 5)
          $display("FAIL sweep%0d_latency got=%0d want=%0d",
                   k, lat, w / s);
      end
      n_cmp++;
      if ({sw_cout[k], sw_ovf[k], sw_zero[k], sw_res[k]} !== exp) begin
        n_bad++;
        if (bad_val++ < 5)
          $display("FAIL sweep%0d op=%b a=%h b=%h got=%h want=%h",
                   k, op, x, y,
                   {sw_cout[k], sw_ovf[k], sw_zero[k], sw_res[k]}, exp);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      sw_start[k] = 1'b0;
      sw_sub[k]   = 1'b0;
      sw_a[k]     = '0;
      sw_b[k]     = '0;
    end
    test_reset();
    test_subtract();
    test_overflow();
    test_ignore_busy();
    test_back_to_back();
    test_mid_reset();
    test_sweep(0, 8, 1);
    test_sweep(1, 8, 8);
    test_sweep(2, 16, 4);
    test_sweep(3, 32, 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
